// File: rtl/axi_lite_gpio_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_gpio_slave
//
// AXI4-Lite slave that exposes a small GPIO block: an LED output register,
// a scratch register, a synchronized view of the GPI inputs and a fixed ID.
//
// Register map (byte offsets, only address bits [4:2] are decoded):
//   0x00 DATA_OUT  RW  drives LED_tri_o (bits at GPIO_W and above read 0)
//   0x04 SCRATCH   RW  general-purpose 32-bit storage
//   0x08 DATA_IN   RO  GPI_tri_i after a 2-flop synchronizer
//   0x0C ID        RO  32'h6770_0001
//   0x10 IRQ_EN    RW  (only with AXI_GPIO_IRQ_EN)
//   0x14 IRQ_STAT  W1C (only with AXI_GPIO_IRQ_EN)
// Unmapped reads return SLVERR with RDATA 0; writes to RO or unmapped
// offsets return SLVERR and change nothing.
//
// Optional feature macro: AXI_GPIO_IRQ_EN adds the IRQ output and the two
// interrupt registers. Any change of a synchronized DATA_IN bit sets its
// IRQ_STAT bit; IRQ = |(IRQ_STAT & IRQ_EN), registered.
//
// Ports:
//   ACLK, ARESETn            clock (rising edge), async active-low reset
//   S_AXI_AW*/W*/B*          AXI-Lite write address / data / response
//   S_AXI_AR*/R*             AXI-Lite read address / data
//   IRQ                      interrupt output (macro builds only)
//   LED_tri_o                DATA_OUT register output
//   GPI_tri_i                asynchronous general-purpose inputs
// ---------------------------------------------------------------------------
module axi_lite_gpio_slave #(
  parameter int ADDR_W = 5,
  parameter int GPIO_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
`ifdef AXI_GPIO_IRQ_EN
  output logic              IRQ,
`endif
  output logic [GPIO_W-1:0] LED_tri_o,
  input  logic [GPIO_W-1:0] GPI_tri_i
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ID_VALUE    = 32'h6770_0001;

  localparam logic [2:0] SEL_DATA_OUT = 3'd0;
  localparam logic [2:0] SEL_SCRATCH  = 3'd1;
  localparam logic [2:0] SEL_DATA_IN  = 3'd2;
  localparam logic [2:0] SEL_ID       = 3'd3;
`ifdef AXI_GPIO_IRQ_EN
  localparam logic [2:0] SEL_IRQ_EN   = 3'd4;
  localparam logic [2:0] SEL_IRQ_STAT = 3'd5;
`endif

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // Byte-lane merge for GPIO_W-wide registers.
  function automatic logic [GPIO_W-1:0] merge_gpio(input logic [GPIO_W-1:0] old_v,
                                                   input logic [31:0]       wdata,
                                                   input logic [3:0]        strb);
    logic [GPIO_W-1:0] res;
    for (int i = 0; i < GPIO_W; i++) begin
      res[i] = strb[i/8] ? wdata[i] : old_v[i];
    end
    return res;
  endfunction

  // Byte-lane merge for full 32-bit registers.
  function automatic logic [31:0] merge_32(input logic [31:0] old_v,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? wdata[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  // Zero-extend a GPIO-wide value onto the 32-bit bus.
  function automatic logic [31:0] zext_gpio(input logic [GPIO_W-1:0] v);
    logic [31:0] res;
    res = '0;
    res[GPIO_W-1:0] = v;
    return res;
  endfunction

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;
  logic     w_hs, r_hs;
  // Holds the READY outputs low until the first edge after reset release.
  logic     rst_done;

  logic [GPIO_W-1:0] data_out;
  logic [31:0]       scratch;
  logic [GPIO_W-1:0] gpi_s1, gpi_s2;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q;

  logic [2:0]  wsel, rsel;
  logic        wr_ok;
  logic [31:0] rdata_n;
  logic [1:0]  rresp_n;

`ifdef AXI_GPIO_IRQ_EN
  logic [GPIO_W-1:0] irq_en, irq_en_n;
  logic [GPIO_W-1:0] irq_stat, irq_stat_n;
  logic [GPIO_W-1:0] gpi_prev;
  logic              irq_q;
`endif

  assign wsel = S_AXI_AWADDR[4:2];
  assign rsel = S_AXI_ARADDR[4:2];

  // Only bits [4:2] of either address take part in decoding.
  logic unused_addr;
  assign unused_addr = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  // Write FSM: state register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) w_state <= W_IDLE;
    else          w_state <= w_state_n;
  end

  // Write FSM: next state and channel handshakes
  always_comb begin
    w_state_n     = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    w_hs          = 1'b0;
    case (w_state)
      W_IDLE: begin
        // Address and data are only taken together.
        if (rst_done && S_AXI_AWVALID && S_AXI_WVALID) begin
          S_AXI_AWREADY = 1'b1;
          S_AXI_WREADY  = 1'b1;
          w_hs          = 1'b1;
          w_state_n     = W_RESP;
        end
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // Read FSM: state register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= R_IDLE;
    else          r_state <= r_state_n;
  end

  // Read FSM: next state and channel handshakes
  always_comb begin
    r_state_n     = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    r_hs          = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = rst_done;
        if (rst_done && S_AXI_ARVALID) begin
          r_hs      = 1'b1;
          r_state_n = R_DATA;
        end
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) r_state_n = R_IDLE;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // Write decode: which offsets accept data
  always_comb begin
    wr_ok = 1'b0;
    case (wsel)
      SEL_DATA_OUT, SEL_SCRATCH: wr_ok = 1'b1;
`ifdef AXI_GPIO_IRQ_EN
      SEL_IRQ_EN, SEL_IRQ_STAT:  wr_ok = 1'b1;
`endif
      default:                   wr_ok = 1'b0;
    endcase
  end

  // Read mux: uses pre-edge register values, so a read that handshakes
  // together with a write to the same register sees the old contents.
  always_comb begin
    rdata_n = '0;
    rresp_n = RESP_OKAY;
    case (rsel)
      SEL_DATA_OUT: rdata_n = zext_gpio(data_out);
      SEL_SCRATCH:  rdata_n = scratch;
      SEL_DATA_IN:  rdata_n = zext_gpio(gpi_s2);
      SEL_ID:       rdata_n = ID_VALUE;
`ifdef AXI_GPIO_IRQ_EN
      SEL_IRQ_EN:   rdata_n = zext_gpio(irq_en);
      SEL_IRQ_STAT: rdata_n = zext_gpio(irq_stat);
`endif
      default:      rresp_n = RESP_SLVERR;
    endcase
  end

`ifdef AXI_GPIO_IRQ_EN
  // Interrupt next state: a fresh change on DATA_IN outranks a W1C.
  always_comb begin
    logic [GPIO_W-1:0] clr;
    irq_en_n = irq_en;
    clr      = '0;
    if (w_hs && wsel == SEL_IRQ_EN)   irq_en_n = merge_gpio(irq_en, S_AXI_WDATA, S_AXI_WSTRB);
    if (w_hs && wsel == SEL_IRQ_STAT) clr      = merge_gpio('0, S_AXI_WDATA, S_AXI_WSTRB);
    irq_stat_n = (irq_stat & ~clr) | (gpi_s2 ^ gpi_prev);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      irq_en   <= '0;
      irq_stat <= '0;
      gpi_prev <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en   <= irq_en_n;
      irq_stat <= irq_stat_n;
      gpi_prev <= gpi_s2;
      // Built from next-state values so IRQ tracks IRQ_STAT without extra lag.
      irq_q    <= |(irq_stat_n & irq_en_n);
    end
  end

  assign IRQ = irq_q;
`endif

  // Register file, synchronizer and response capture
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rst_done <= 1'b0;
      data_out <= '0;
      scratch  <= '0;
      gpi_s1   <= '0;
      gpi_s2   <= '0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      rst_done <= 1'b1;
      gpi_s1   <= GPI_tri_i;
      gpi_s2   <= gpi_s1;
      if (w_hs) begin
        bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wsel == SEL_DATA_OUT) data_out <= merge_gpio(data_out, S_AXI_WDATA, S_AXI_WSTRB);
        if (wsel == SEL_SCRATCH)  scratch  <= merge_32(scratch, S_AXI_WDATA, S_AXI_WSTRB);
      end
      if (r_hs) begin
        rdata_q <= rdata_n;
        rresp_q <= rresp_n;
      end
    end
  end

  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;
  assign LED_tri_o   = data_out;

endmodule

// File: tb/tb_axi_lite_gpio_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_gpio_slave
//
// Directed self-checking bench for axi_lite_gpio_slave (default parameters).
// Each task exercises one feature and compares DUT outputs against
// hand-computed values. Inputs change 1 time unit after the rising edge,
// outputs are sampled there as well.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_lite_gpio_slave;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        tb_ACLK = 1'b0;
  logic        ARESETn;
  logic [4:0]  S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [4:0]  S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
`ifdef AXI_GPIO_IRQ_EN
  logic        IRQ;
`endif
  logic [31:0] LED_tri_o;
  logic [31:0] GPI_tri_i;

  logic        loop_en;
  logic [31:0] gpi_drv;
  int          tests_run    = 0;
  int          tests_failed = 0;

  assign GPI_tri_i = loop_en ? LED_tri_o : gpi_drv;

  always #5 tb_ACLK = ~tb_ACLK;

  axi_lite_gpio_slave dut (
    .ACLK          (tb_ACLK),
    .ARESETn       (ARESETn),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
`ifdef AXI_GPIO_IRQ_EN
    .IRQ           (IRQ),
`endif
    .LED_tri_o     (LED_tri_o),
    .GPI_tri_i     (GPI_tri_i)
  );

  // Bus access helpers: entered and left 1 unit after a rising edge.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    #1;
    n = 0;
    while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 50) begin @(posedge tb_ACLK); #1; n++; end
    if (n >= 50) begin
      tests_run++; tests_failed++;
      $display("FAIL axi_write_aw_timeout: awready=%0b, required 1", S_AXI_AWREADY);
    end
    @(posedge tb_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin @(posedge tb_ACLK); #1; n++; end
    if (n >= 50) begin
      tests_run++; tests_failed++;
      $display("FAIL axi_write_b_timeout: bvalid=%0b, required 1", S_AXI_BVALID);
    end
    resp = S_AXI_BRESP;
    @(posedge tb_ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    #1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(posedge tb_ACLK); #1; n++; end
    if (n >= 50) begin
      tests_run++; tests_failed++;
      $display("FAIL axi_read_ar_timeout: arready=%0b, required 1", S_AXI_ARREADY);
    end
    @(posedge tb_ACLK); #1;
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    n = 0;
    while (!S_AXI_RVALID && n < 50) begin @(posedge tb_ACLK); #1; n++; end
    if (n >= 50) begin
      tests_run++; tests_failed++;
      $display("FAIL axi_read_r_timeout: rvalid=%0b, required 1", S_AXI_RVALID);
    end
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    @(posedge tb_ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    repeat (3) @(posedge tb_ACLK);
    #1;
    tests_run++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b, required 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    tests_run++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_valid_resp: got %b, required 000000", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP});
    end
    tests_run++;
    if (S_AXI_RDATA !== 32'h0 || LED_tri_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: rdata=%h led=%h, required 0/0", S_AXI_RDATA, LED_tri_o);
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    ARESETn = 1'b1;
    @(posedge tb_ACLK); #1;
    tests_run++;
    if (S_AXI_ARREADY !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_arready_after: got %b, required 1", S_AXI_ARREADY);
    end
  endtask

  task automatic test_write_basic();
    S_AXI_AWADDR = 5'h00; S_AXI_WDATA = 32'hDEADA5A5; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    #1;
    tests_run++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, LED_tri_o} !== {2'b11, 32'h0}) begin
      tests_failed++;
      $display("FAIL wr_pre_edge: ready=%b led=%h, required 11/00000000", {S_AXI_AWREADY, S_AXI_WREADY}, LED_tri_o);
    end
    @(posedge tb_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tests_run++;
    if (LED_tri_o !== 32'hDEADA5A5) begin
      tests_failed++;
      $display("FAIL wr_led: got %h, required DEADA5A5", LED_tri_o);
    end
    tests_run++;
    if ({S_AXI_BVALID, S_AXI_BRESP} !== {1'b1, OKAY}) begin
      tests_failed++;
      $display("FAIL wr_bresp: got %b, required 100", {S_AXI_BVALID, S_AXI_BRESP});
    end
    S_AXI_BREADY = 1'b1;
    @(posedge tb_ACLK); #1;
    S_AXI_BREADY = 1'b0;
    tests_run++;
    if (S_AXI_BVALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_bvalid_drop: got %b, required 0", S_AXI_BVALID);
    end
  endtask

  task automatic test_gpi_loopback();
    logic [31:0] d; logic [1:0] r;
    loop_en = 1'b1;
    repeat (3) @(posedge tb_ACLK);
    #1;
    axi_read(5'h08, d, r);
    tests_run++;
    if ({d, r} !== {32'hDEADA5A5, OKAY}) begin
      tests_failed++;
      $display("FAIL loop_data_in: got %h/%b, required DEADA5A5/00", d, r);
    end
    tests_run++;
    if (d[3:0] !== 4'h5) begin
      tests_failed++;
      $display("FAIL loop_low_nibble: got %h, required 5", d[3:0]);
    end
  endtask

  task automatic test_wstrb();
    logic [31:0] d; logic [1:0] r;
    axi_write(5'h00, 32'h00001200, 4'b0010, r);
    axi_read(5'h00, d, r);
    tests_run++;
    if ({d, r, LED_tri_o} !== {32'hDEAD12A5, OKAY, 32'hDEAD12A5}) begin
      tests_failed++;
      $display("FAIL wstrb_lane1: rdata=%h resp=%b led=%h, required DEAD12A5/00/DEAD12A5", d, r, LED_tri_o);
    end
  endtask

  task automatic test_scratch();
    logic [31:0] d; logic [1:0] r, b;
    axi_write(5'h04, 32'h12345678, 4'hF, b);
    axi_write(5'h04, 32'hAABBCCDD, 4'b1001, b);
    axi_read(5'h04, d, r);
    tests_run++;
    if ({d, r, b} !== {32'hAA3456DD, OKAY, OKAY}) begin
      tests_failed++;
      $display("FAIL scratch_rw: rdata=%h rresp=%b bresp=%b, required AA3456DD/00/00", d, r, b);
    end
  endtask

  task automatic test_id_and_errors();
    logic [31:0] d; logic [1:0] r, b;
    axi_read(5'h0C, d, r);
    tests_run++;
    if ({d, r} !== {32'h67700001, OKAY}) begin
      tests_failed++;
      $display("FAIL id_read: got %h/%b, required 67700001/00", d, r);
    end
    axi_read(5'h1C, d, r);
    tests_run++;
    if ({d, r} !== {32'h0, SLVERR}) begin
      tests_failed++;
      $display("FAIL unmapped_read: got %h/%b, required 00000000/10", d, r);
    end
    axi_write(5'h0C, 32'hFFFFFFFF, 4'hF, b);
    axi_read(5'h0C, d, r);
    tests_run++;
    if ({b, d} !== {SLVERR, 32'h67700001}) begin
      tests_failed++;
      $display("FAIL id_write: bresp=%b id=%h, required 10/67700001", b, d);
    end
    axi_write(5'h08, 32'h0, 4'hF, b);
    tests_run++;
    if (b !== SLVERR) begin
      tests_failed++;
      $display("FAIL data_in_write: bresp=%b, required 10", b);
    end
    axi_write(5'h1C, 32'h0, 4'hF, b);
    axi_read(5'h00, d, r);
    tests_run++;
    if ({b, d} !== {SLVERR, 32'hDEAD12A5}) begin
      tests_failed++;
      $display("FAIL unmapped_write: bresp=%b data_out=%h, required 10/DEAD12A5", b, d);
    end
`ifndef AXI_GPIO_IRQ_EN
    axi_write(5'h10, 32'h1, 4'hF, b);
    axi_read(5'h14, d, r);
    tests_run++;
    if ({b, r, d} !== {SLVERR, SLVERR, 32'h0}) begin
      tests_failed++;
      $display("FAIL irq_regs_absent: bresp=%b rresp=%b rdata=%h, required 10/10/0", b, r, d);
    end
`endif
  endtask

  task automatic test_bready_hold();
    logic [31:0] d; logic [1:0] r;
    S_AXI_AWADDR = 5'h04; S_AXI_WDATA = 32'h11111111; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    @(posedge tb_ACLK); #1;
    S_AXI_WDATA = 32'h22222222;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP} !== 5'b10000) begin
        tests_failed++;
        $display("FAIL bhold_cycle%0d: bvalid/awready/wready/bresp=%b, required 10000", k,
                 {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP});
      end
      @(posedge tb_ACLK); #1;
    end
    S_AXI_BREADY = 1'b1;
    @(posedge tb_ACLK); #1;
    tests_run++;
    if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011) begin
      tests_failed++;
      $display("FAIL bhold_second_accept: bvalid/awready/wready=%b, required 011", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
    end
    @(posedge tb_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tests_run++;
    if (S_AXI_BVALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL bhold_second_b: bvalid=%b, required 1", S_AXI_BVALID);
    end
    @(posedge tb_ACLK); #1;
    S_AXI_BREADY = 1'b0;
    axi_read(5'h04, d, r);
    tests_run++;
    if (d !== 32'h22222222) begin
      tests_failed++;
      $display("FAIL bhold_scratch: got %h, required 22222222", d);
    end
  endtask

  task automatic test_rvalid_hold();
    S_AXI_ARADDR = 5'h04; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    @(posedge tb_ACLK); #1;
    S_AXI_ARVALID = 1'b0; S_AXI_ARADDR = 5'h0C;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RRESP, S_AXI_RDATA} !== {2'b10, OKAY, 32'h22222222}) begin
        tests_failed++;
        $display("FAIL rhold_cycle%0d: rvalid/arready=%b rresp=%b rdata=%h, required 10/00/22222222", k,
                 {S_AXI_RVALID, S_AXI_ARREADY}, S_AXI_RRESP, S_AXI_RDATA);
      end
      @(posedge tb_ACLK); #1;
    end
    S_AXI_RREADY = 1'b1;
    @(posedge tb_ACLK); #1;
    S_AXI_RREADY = 1'b0;
    tests_run++;
    if ({S_AXI_RVALID, S_AXI_ARREADY} !== 2'b01) begin
      tests_failed++;
      $display("FAIL rhold_release: rvalid/arready=%b, required 01", {S_AXI_RVALID, S_AXI_ARREADY});
    end
  endtask

  task automatic test_simul_rw();
    logic [31:0] d; logic [1:0] r;
    S_AXI_AWADDR = 5'h00; S_AXI_WDATA = 32'h0F0F0F0F; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1'b1;
    #1;
    tests_run++;
    if ({S_AXI_AWREADY, S_AXI_ARREADY} !== 2'b11) begin
      tests_failed++;
      $display("FAIL simul_ready: awready/arready=%b, required 11", {S_AXI_AWREADY, S_AXI_ARREADY});
    end
    @(posedge tb_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    tests_run++;
    if ({S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA, LED_tri_o} !== {2'b11, 32'hDEAD12A5, 32'h0F0F0F0F}) begin
      tests_failed++;
      $display("FAIL simul_old_value: rvalid/bvalid=%b rdata=%h led=%h, required 11/DEAD12A5/0F0F0F0F",
               {S_AXI_RVALID, S_AXI_BVALID}, S_AXI_RDATA, LED_tri_o);
    end
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    @(posedge tb_ACLK); #1;
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    axi_read(5'h00, d, r);
    tests_run++;
    if (d !== 32'h0F0F0F0F) begin
      tests_failed++;
      $display("FAIL simul_new_value: got %h, required 0F0F0F0F", d);
    end
  endtask

  task automatic test_sync_latency();
    logic [31:0] d; logic [1:0] r;
    loop_en = 1'b0; gpi_drv = 32'h12345678;
    repeat (3) @(posedge tb_ACLK);
    #1;
    gpi_drv = 32'h87654321;
    @(posedge tb_ACLK); #1;
    // This read handshakes on the second edge after the input change.
    axi_read(5'h08, d, r);
    tests_run++;
    if (d !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL sync_two_flop: got %h, required 12345678", d);
    end
    axi_read(5'h08, d, r);
    tests_run++;
    if (d !== 32'h87654321) begin
      tests_failed++;
      $display("FAIL sync_settled: got %h, required 87654321", d);
    end
  endtask

`ifdef AXI_GPIO_IRQ_EN
  task automatic test_irq();
    logic [31:0] d; logic [1:0] r, b;
    int n;
    axi_write(5'h14, 32'hFFFFFFFF, 4'hF, b);
    axi_write(5'h10, 32'h00000001, 4'hF, b);
    tests_run++;
    if ({IRQ, b} !== {1'b0, OKAY}) begin
      tests_failed++;
      $display("FAIL irq_idle: irq=%b bresp=%b, required 0/00", IRQ, b);
    end
    gpi_drv = gpi_drv ^ 32'h1;
    n = 0;
    while (!IRQ && n < 3) begin @(posedge tb_ACLK); #1; n++; end
    tests_run++;
    if (IRQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_assert: irq=%b after %0d cycles, required 1", IRQ, n);
    end
    axi_read(5'h14, d, r);
    tests_run++;
    if ({d, r} !== {32'h1, OKAY}) begin
      tests_failed++;
      $display("FAIL irq_stat_read: got %h/%b, required 00000001/00", d, r);
    end
    S_AXI_AWADDR = 5'h14; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge tb_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tests_run++;
    if (IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_w1c: irq=%b, required 0", IRQ);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge tb_ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r;
    S_AXI_AWADDR = 5'h00; S_AXI_WDATA = 32'hFFFFFFFF; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 5'h04; S_AXI_ARVALID = 1'b1;
    @(posedge tb_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    tests_run++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA, LED_tri_o} !== {2'b11, 32'h22222222, 32'hFFFFFFFF}) begin
      tests_failed++;
      $display("FAIL midrst_pending: bvalid/rvalid=%b rdata=%h led=%h, required 11/22222222/FFFFFFFF",
               {S_AXI_BVALID, S_AXI_RVALID}, S_AXI_RDATA, LED_tri_o);
    end
    ARESETn = 1'b0;
    #1;
    tests_run++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_ARREADY, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, LED_tri_o} !== 71'b0) begin
      tests_failed++;
      $display("FAIL midrst_clear: bvalid/rvalid/arready=%b rdata=%h led=%h, required 000/0/0",
               {S_AXI_BVALID, S_AXI_RVALID, S_AXI_ARREADY}, S_AXI_RDATA, LED_tri_o);
    end
    @(posedge tb_ACLK); #1;
    ARESETn = 1'b1;
    @(posedge tb_ACLK); #1;
    tests_run++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_ARREADY} !== 3'b001) begin
      tests_failed++;
      $display("FAIL midrst_after: bvalid/rvalid/arready=%b, required 001", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_ARREADY});
    end
    axi_read(5'h04, d, r);
    tests_run++;
    if ({d, r} !== {32'h0, OKAY}) begin
      tests_failed++;
      $display("FAIL midrst_scratch: got %h/%b, required 00000000/00", d, r);
    end
  endtask

  initial begin
    ARESETn = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    loop_en = 1'b0; gpi_drv = '0;
    test_reset();
    test_write_basic();
    test_gpi_loopback();
    test_wstrb();
    test_scratch();
    test_id_and_errors();
    test_bready_hold();
    test_rvalid_hold();
    test_simul_rw();
    test_sync_latency();
`ifdef AXI_GPIO_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
